// File: rtl/pong_pkg.sv
// Shared Pong definitions: playfield defaults, paddle FSM states and direction encoding.
package pong_pkg;

  localparam int unsigned FIELD_H_DEF  = 16;
  localparam int unsigned PADDLE_H_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } axis_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Opposing keys cancel; a single key gives its direction.
  function automatic dir_e resolve_dir(input logic up, input logic down);
    case ({up, down})
      2'b10:   return DIR_UP;
      2'b01:   return DIR_DOWN;
      default: return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle: press/hold/auto-repeat FSM, tick counter and clamped y register.
// Optional PADDLE_ACCEL_EN halves the repeat interval after 4 repeat moves.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int unsigned FIELD_H    = FIELD_H_DEF,
  parameter int unsigned PADDLE_H   = PADDLE_H_DEF,
  parameter int unsigned Y_W        = 4,
  parameter int unsigned HOLD_DELAY = 30,
  parameter int unsigned STEP_DIV   = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  dir_e           dir_i,
  input  logic           freeze_i,
  input  logic           recenter_i,
  output logic [Y_W-1:0] y_o,
  output logic           moving_o
);

  localparam int unsigned Y_MAX   = FIELD_H - PADDLE_H;
  localparam int unsigned Y_CTR   = Y_MAX / 2;
  localparam int unsigned CNT_MAX = (HOLD_DELAY > STEP_DIV) ? HOLD_DELAY : STEP_DIV;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [Y_W:0]     Y_MAX_X   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0]   Y_CTR_Y   = Y_W'(Y_CTR);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

  axis_state_e    state_q, state_d;
  dir_e           dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           moving_q, moving_d;

  logic           step;
  dir_e           step_dir;
  logic [Y_W:0]   y_try;
  logic [CNT_W-1:0] step_last;

`ifdef PADDLE_ACCEL_EN
  localparam int unsigned FAST_DIV = (STEP_DIV / 2 < 1) ? 1 : STEP_DIV / 2;
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  logic [2:0] rep_q, rep_d;

  assign step_last = (rep_q >= 3'd4) ? FAST_LAST : STEP_LAST;
`else
  assign step_last = STEP_LAST;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_NONE;
      cnt_q    <= '0;
      y_q      <= Y_CTR_Y;
      moving_q <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      rep_q    <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      moving_q <= moving_d;
`ifdef PADDLE_ACCEL_EN
      rep_q    <= rep_d;
`endif
    end
  end

  // Next state, step request and clamped position update
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    moving_d = 1'b0;
    step     = 1'b0;
    step_dir = dir_i;
    y_try    = '0;
`ifdef PADDLE_ACCEL_EN
    rep_d    = rep_q;
`endif

    if (recenter_i) begin
      state_d = ST_IDLE;
      dir_d   = DIR_NONE;
      cnt_d   = '0;
      y_d     = Y_CTR_Y;
    end else if (freeze_i) begin
      state_d = ST_IDLE;
      dir_d   = DIR_NONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (dir_i != DIR_NONE) begin
            step    = 1'b1;
            dir_d   = dir_i;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dir_i == DIR_NONE) begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            cnt_d   = '0;
          end else if (dir_i != dir_q) begin
            step  = 1'b1;
            dir_d = dir_i;
            cnt_d = '0;
          end else if (cnt_q >= HOLD_LAST) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (dir_i == DIR_NONE) begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
            cnt_d   = '0;
          end else if (dir_i != dir_q) begin
            step    = 1'b1;
            dir_d   = dir_i;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else if (cnt_q >= step_last) begin
            step  = 1'b1;
            cnt_d = '0;
`ifdef PADDLE_ACCEL_EN
            if (rep_q < 3'd4) rep_d = rep_q + 3'd1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          dir_d   = DIR_NONE;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef PADDLE_ACCEL_EN
    if (state_d != ST_REPEAT) rep_d = 3'd0;
`endif

    // One extra bit so 0-1 lands far above Y_MAX instead of wrapping to a legal row
    if (step) begin
      if (step_dir == DIR_UP) y_try = {1'b0, y_q} - (Y_W+1)'(1);
      else                    y_try = {1'b0, y_q} + (Y_W+1)'(1);
      if (y_try <= Y_MAX_X) begin
        y_d      = y_try[Y_W-1:0];
        moving_d = 1'b1;
      end
    end
  end

  assign y_o      = y_q;
  assign moving_o = moving_q;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Two independent paddle axes driven by keypad command levels, with freeze and recenter.
// Build option: PADDLE_ACCEL_EN enables repeat acceleration in each axis.
module paddle_motion_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned FIELD_H    = FIELD_H_DEF,
  parameter int unsigned PADDLE_H   = PADDLE_H_DEF,
  parameter int unsigned Y_W        = 4,
  parameter int unsigned HOLD_DELAY = 30,
  parameter int unsigned STEP_DIV   = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up1,
  input  logic           down1,
  input  logic           up2,
  input  logic           down2,
  input  logic           freeze,
  input  logic           recenter,
  output logic [Y_W-1:0] paddle1_y,
  output logic [Y_W-1:0] paddle2_y,
  output logic           moving1,
  output logic           moving2
);

  dir_e dir1;
  dir_e dir2;
  logic hold_en;

  assign dir1    = resolve_dir(up1, down1);
  assign dir2    = resolve_dir(up2, down2);
  // recenter outranks freeze, so freeze is masked in a recenter cycle
  assign hold_en = freeze & ~recenter;

  paddle_axis #(
    .FIELD_H    (FIELD_H),
    .PADDLE_H   (PADDLE_H),
    .Y_W        (Y_W),
    .HOLD_DELAY (HOLD_DELAY),
    .STEP_DIV   (STEP_DIV)
  ) u_axis1 (
    .clk        (clk),
    .rst        (rst),
    .dir_i      (dir1),
    .freeze_i   (hold_en),
    .recenter_i (recenter),
    .y_o        (paddle1_y),
    .moving_o   (moving1)
  );

  paddle_axis #(
    .FIELD_H    (FIELD_H),
    .PADDLE_H   (PADDLE_H),
    .Y_W        (Y_W),
    .HOLD_DELAY (HOLD_DELAY),
    .STEP_DIV   (STEP_DIV)
  ) u_axis2 (
    .clk        (clk),
    .rst        (rst),
    .dir_i      (dir2),
    .freeze_i   (hold_en),
    .recenter_i (recenter),
    .y_o        (paddle2_y),
    .moving_o   (moving2)
  );

endmodule
